input_scan_controller: RTL and testbench

- Sequences PLC input sampling as a scan cycle: synchronises the raw input pins, then freezes a consistent input image on request.
- Arbitrates single-bit reads of that image between two requesters: the processor core (CPU) and a peripheral port (timer/counter block).
- Sits between the external input pins and the core's input-read path. Reads are always served from the frozen image, never from live pins.

---
 rtl/input_scan_controller_pkg.sv | 16 +
 rtl/input_sync2.sv | 25 ++
 rtl/input_scan_controller.sv | 158 +++++++++++++++
 tb/tb_input_scan_controller.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/input_scan_controller_pkg.sv
// Shared defines for the PLC input scan path: input count, read-address width
// and the scan FSM state encoding. Same values the core's input-read path uses.
// No ports; imported by the scan controller.
package input_scan_controller_pkg;

  localparam int INPUT_NUM = 8;
  localparam int ADDR_LEN  = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } scan_state_t;

endpackage

// File: rtl/input_sync2.sv
// Two-flop synchroniser for a bus of independent asynchronous input pins.
// Latency: 2 cycles from d to q. No backpressure; samples every cycle.
// Ports: clk, reset (sync, active-high), d (raw pins), q (synchronised).
module input_sync2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/input_scan_controller.sv
// Scan-cycle input sampler: freezes a synchronised input image on scan_req and
// serves single-bit reads to CPU and peripheral from that image (round-robin).
// Latency: scan_done at T+SETTLE_CYCLES+2; read ack/data 1 cycle after grant.
// Backpressure: requesters hold req until ack; CAPTURE stalls both for a cycle.
// Ports: clk, reset (sync, active-high), inputs, scan_req/busy/done,
//        cpu_rd_req/addr/ack/data, per_rd_req/addr/ack/data, rd_addr_err.
module input_scan_controller #(
  parameter int INPUT_NUM     = input_scan_controller_pkg::INPUT_NUM,
  parameter int ADDR_LEN      = input_scan_controller_pkg::ADDR_LEN,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [INPUT_NUM-1:0] inputs,
  input  logic                 scan_req,
  output logic                 scan_busy,
  output logic                 scan_done,
  input  logic                 cpu_rd_req,
  input  logic [ADDR_LEN-1:0]  cpu_rd_addr,
  output logic                 cpu_rd_ack,
  output logic                 cpu_rd_data,
  input  logic                 per_rd_req,
  input  logic [ADDR_LEN-1:0]  per_rd_addr,
  output logic                 per_rd_ack,
  output logic                 per_rd_data,
  output logic                 rd_addr_err
);
  import input_scan_controller_pkg::*;

  localparam int                IMG_W       = 1 << ADDR_LEN;
  localparam logic [3:0]        SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [ADDR_LEN:0] NUM_BITS    = (ADDR_LEN + 1)'(INPUT_NUM);

  logic [INPUT_NUM-1:0] sync_q;
  logic [INPUT_NUM-1:0] image;
  logic [IMG_W-1:0]     image_ext;

  scan_state_t state, state_nxt;
  logic [3:0]  settle_cnt, settle_cnt_nxt;
  logic        capture_en;

  logic                grant_cpu, grant_per;
  logic                ptr_per;      // 1: peripheral wins the next contended cycle
  logic [ADDR_LEN-1:0] rd_sel_addr;
  logic                rd_bit;
  logic                rd_oor;

  input_sync2 #(.WIDTH(INPUT_NUM)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (inputs),
    .q     (sync_q)
  );

  // ---------------------------------------------------------------- scan FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      settle_cnt <= '0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    settle_cnt_nxt = settle_cnt;
    scan_busy      = (state != IDLE);
    scan_done      = 1'b0;
    capture_en     = 1'b0;
    case (state)
      IDLE: begin
        if (scan_req) begin
          state_nxt      = SETTLE;
          settle_cnt_nxt = '0;
        end
      end
      SETTLE: begin
        if (settle_cnt == SETTLE_LAST) begin
          state_nxt = CAPTURE;
        end else begin
          settle_cnt_nxt = settle_cnt + 4'd1;
        end
      end
      CAPTURE: begin
        capture_en = 1'b1;
        state_nxt  = DONE;
      end
      DONE: begin
        scan_done = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The image only ever changes at the end of CAPTURE, so every read sees
  // either the whole old scan or the whole new one.
  always_ff @(posedge clk) begin
    if (reset) begin
      image <= '0;
    end else if (capture_en) begin
      image <= sync_q;
    end
  end

  // Zero-padded to the full address space so out-of-range reads return 0.
  always_comb begin
    image_ext                  = '0;
    image_ext[INPUT_NUM-1:0]   = image;
  end

  // ---------------------------------------------------------------- arbiter
  // No grants in CAPTURE: the image is being overwritten at that edge.
  always_comb begin
    grant_cpu = 1'b0;
    grant_per = 1'b0;
    if (!capture_en) begin
      if (cpu_rd_req && per_rd_req) begin
        grant_per = ptr_per;
        grant_cpu = !ptr_per;
      end else begin
        grant_cpu = cpu_rd_req;
        grant_per = per_rd_req;
      end
    end
  end

  assign rd_sel_addr = grant_per ? per_rd_addr : cpu_rd_addr;
  assign rd_bit      = image_ext[rd_sel_addr];
  assign rd_oor      = ({1'b0, rd_sel_addr} >= NUM_BITS);

  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_rd_ack  <= 1'b0;
      per_rd_ack  <= 1'b0;
      cpu_rd_data <= 1'b0;
      per_rd_data <= 1'b0;
      rd_addr_err <= 1'b0;
      ptr_per     <= 1'b0;
    end else begin
      cpu_rd_ack  <= grant_cpu;
      per_rd_ack  <= grant_per;
      rd_addr_err <= (grant_cpu || grant_per) && rd_oor;
      // After any grant the other side gets priority next time both ask.
      if (grant_cpu) begin
        cpu_rd_data <= rd_bit;
        ptr_per     <= 1'b1;
      end
      if (grant_per) begin
        per_rd_data <= rd_bit;
        ptr_per     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_input_scan_controller.sv
module tb_input_scan_controller;

  localparam int SETTLE = 2;

  logic       clk;
  logic       reset;
  logic [7:0] pins;
  logic       scan_req;
  logic       cpu_rd_req, per_rd_req;
  logic [2:0] cpu_rd_addr, per_rd_addr;

  logic scan_busy, scan_done, cpu_rd_ack, cpu_rd_data, per_rd_ack, per_rd_data, rd_addr_err;
  logic scan_busy6, scan_done6, cpu_rd_ack6, cpu_rd_data6, per_rd_ack6, per_rd_data6, rd_addr_err6;

  int checks = 0;
  int passed = 0;
  logic [7:0] exp_img;

  input_scan_controller #(.INPUT_NUM(8), .ADDR_LEN(3), .SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .reset(reset), .inputs(pins), .scan_req(scan_req),
    .scan_busy(scan_busy), .scan_done(scan_done),
    .cpu_rd_req(cpu_rd_req), .cpu_rd_addr(cpu_rd_addr), .cpu_rd_ack(cpu_rd_ack), .cpu_rd_data(cpu_rd_data),
    .per_rd_req(per_rd_req), .per_rd_addr(per_rd_addr), .per_rd_ack(per_rd_ack), .per_rd_data(per_rd_data),
    .rd_addr_err(rd_addr_err)
  );

  // Narrower instance sharing all stimulus; its image is pins[5:0].
  input_scan_controller #(.INPUT_NUM(6), .ADDR_LEN(3), .SETTLE_CYCLES(SETTLE)) dut6 (
    .clk(clk), .reset(reset), .inputs(pins[5:0]), .scan_req(scan_req),
    .scan_busy(scan_busy6), .scan_done(scan_done6),
    .cpu_rd_req(cpu_rd_req), .cpu_rd_addr(cpu_rd_addr), .cpu_rd_ack(cpu_rd_ack6), .cpu_rd_data(cpu_rd_data6),
    .per_rd_req(per_rd_req), .per_rd_addr(per_rd_addr), .per_rd_ack(per_rd_ack6), .per_rd_data(per_rd_data6),
    .rd_addr_err(rd_addr_err6)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    scan_req    = 1'b0;
    cpu_rd_req  = 1'b0;
    per_rd_req  = 1'b0;
    cpu_rd_addr = 3'd0;
    per_rd_addr = 3'd0;
  endtask

  task automatic cpu_read(input logic [2:0] a);
    cpu_rd_addr = a;
    cpu_rd_req  = 1'b1;
    tick();
    cpu_rd_req  = 1'b0;
  endtask

  task automatic per_read(input logic [2:0] a);
    per_rd_addr = a;
    per_rd_req  = 1'b1;
    tick();
    per_rd_req  = 1'b0;
  endtask

  task automatic do_scan(input logic [7:0] v);
    int n;
    pins     = v;
    scan_req = 1'b1;
    tick();
    scan_req = 1'b0;
    n = 0;
    while (scan_done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (scan_done !== 1'b1) $display("FAIL scan_timeout: scan_done=%b after %0d cycles, required 1", scan_done, n);
    else passed++;
    exp_img = v;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    pins  = 8'hFF;
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({scan_busy, scan_done, cpu_rd_ack, cpu_rd_data, per_rd_ack, per_rd_data, rd_addr_err} !== 7'b0)
      $display("FAIL reset_outputs: got %b, required 0000000",
               {scan_busy, scan_done, cpu_rd_ack, cpu_rd_data, per_rd_ack, per_rd_data, rd_addr_err});
    else passed++;
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if ({scan_busy, scan_done, cpu_rd_ack, per_rd_ack, rd_addr_err} !== 5'b0)
      $display("FAIL idle_outputs: got %b, required 00000",
               {scan_busy, scan_done, cpu_rd_ack, per_rd_ack, rd_addr_err});
    else passed++;
    cpu_read(3'd3);
    checks++;
    if ({cpu_rd_ack, cpu_rd_data, per_rd_ack, rd_addr_err} !== 4'b1000)
      $display("FAIL reset_read: ack/data/per_ack/err=%b, required 1000",
               {cpu_rd_ack, cpu_rd_data, per_rd_ack, rd_addr_err});
    else passed++;
    tick();
    checks++;
    if (cpu_rd_ack !== 1'b0) $display("FAIL ack_pulse: cpu_rd_ack=%b, required 0", cpu_rd_ack);
    else passed++;
  endtask

  task automatic test_basic_scan();
    logic e_busy, e_done;
    pins = 8'hA5;
    tick();
    tick();
    tick();
    scan_req = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      scan_req = 1'b0;
      e_busy = (i <= SETTLE + 2);
      e_done = (i == SETTLE + 2);
      checks++;
      if ({scan_busy, scan_done} !== {e_busy, e_done})
        $display("FAIL scan_timing T+%0d: busy/done=%b, required %b", i, {scan_busy, scan_done}, {e_busy, e_done});
      else passed++;
    end
    exp_img = 8'hA5;
    for (int a = 0; a < 3; a++) begin
      cpu_read(3'(a));
      checks++;
      if ({cpu_rd_ack, cpu_rd_data} !== {1'b1, exp_img[a]})
        $display("FAIL basic_read addr %0d: ack/data=%b, required %b", a, {cpu_rd_ack, cpu_rd_data}, {1'b1, exp_img[a]});
      else passed++;
    end
  endtask

  task automatic test_freeze();
    logic [2:0] addrs [4];
    addrs = '{3'd0, 3'd2, 3'd5, 3'd7};
    pins = 8'h00;
    repeat (4) tick();
    foreach (addrs[k]) begin
      cpu_read(addrs[k]);
      checks++;
      if ({cpu_rd_ack, cpu_rd_data} !== {1'b1, exp_img[addrs[k]]})
        $display("FAIL freeze_read addr %0d: ack/data=%b, required %b",
                 addrs[k], {cpu_rd_ack, cpu_rd_data}, {1'b1, exp_img[addrs[k]]});
      else passed++;
    end
    do_scan(8'h00);
    foreach (addrs[k]) begin
      cpu_read(addrs[k]);
      checks++;
      if ({cpu_rd_ack, cpu_rd_data} !== {1'b1, exp_img[addrs[k]]})
        $display("FAIL rescan_read addr %0d: ack/data=%b, required %b",
                 addrs[k], {cpu_rd_ack, cpu_rd_data}, {1'b1, exp_img[addrs[k]]});
      else passed++;
    end
  endtask

  task automatic test_contention();
    logic e_c, e_p;
    do_scan(8'h81);
    // A lone peripheral read hands priority back to the CPU.
    per_read(3'd3);
    checks++;
    if ({per_rd_ack, per_rd_data, cpu_rd_ack} !== {1'b1, exp_img[3], 1'b0})
      $display("FAIL per_read: ack/data/cpu_ack=%b, required %b",
               {per_rd_ack, per_rd_data, cpu_rd_ack}, {1'b1, exp_img[3], 1'b0});
    else passed++;
    cpu_rd_addr = 3'd0;
    per_rd_addr = 3'd7;
    cpu_rd_req  = 1'b1;
    per_rd_req  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      e_c = (i % 2 == 0);
      e_p = !e_c;
      checks++;
      if ({cpu_rd_ack, per_rd_ack} !== {e_c, e_p})
        $display("FAIL contention_acks cycle %0d: cpu/per ack=%b, required %b", i, {cpu_rd_ack, per_rd_ack}, {e_c, e_p});
      else passed++;
      checks++;
      if ((e_c ? cpu_rd_data : per_rd_data) !== 1'b1)
        $display("FAIL contention_data cycle %0d: data=%b, required 1", i, e_c ? cpu_rd_data : per_rd_data);
      else passed++;
    end
    cpu_rd_req = 1'b0;
    per_rd_req = 1'b0;
    tick();
    checks++;
    if ({cpu_rd_ack, per_rd_ack} !== 2'b00)
      $display("FAIL contention_release: cpu/per ack=%b, required 00", {cpu_rd_ack, per_rd_ack});
    else passed++;
  endtask

  task automatic test_capture_stall();
    logic [7:0] old_img;
    old_img  = exp_img;
    pins     = 8'h3C;
    scan_req = 1'b1;
    tick();                                    // SETTLE, first cycle
    scan_req = 1'b0;
    tick();                                    // SETTLE, last cycle
    per_rd_addr = 3'd2;
    per_rd_req  = 1'b1;
    tick();                                    // CAPTURE
    checks++;
    if ({per_rd_ack, per_rd_data} !== {1'b1, old_img[2]})
      $display("FAIL pre_capture_read: ack/data=%b, required %b", {per_rd_ack, per_rd_data}, {1'b1, old_img[2]});
    else passed++;
    per_rd_req  = 1'b0;
    cpu_rd_addr = 3'd2;
    cpu_rd_req  = 1'b1;
    tick();                                    // DONE
    checks++;
    if ({scan_done, cpu_rd_ack, per_rd_ack} !== 3'b100)
      $display("FAIL capture_stall: done/cpu_ack/per_ack=%b, required 100", {scan_done, cpu_rd_ack, per_rd_ack});
    else passed++;
    tick();
    cpu_rd_req = 1'b0;
    exp_img    = 8'h3C;
    checks++;
    if ({cpu_rd_ack, cpu_rd_data} !== {1'b1, exp_img[2]})
      $display("FAIL done_read: ack/data=%b, required %b", {cpu_rd_ack, cpu_rd_data}, {1'b1, exp_img[2]});
    else passed++;
    tick();
  endtask

  task automatic test_addr_err();
    do_scan(8'hFF);
    cpu_read(3'd7);
    checks++;
    if ({cpu_rd_ack, cpu_rd_data, rd_addr_err} !== {1'b1, exp_img[7], 1'b0})
      $display("FAIL err8_addr7: ack/data/err=%b, required %b", {cpu_rd_ack, cpu_rd_data, rd_addr_err}, {1'b1, exp_img[7], 1'b0});
    else passed++;
    checks++;
    if ({cpu_rd_ack6, cpu_rd_data6, rd_addr_err6} !== 3'b101)
      $display("FAIL err6_addr7: ack/data/err=%b, required 101", {cpu_rd_ack6, cpu_rd_data6, rd_addr_err6});
    else passed++;
    per_read(3'd6);
    checks++;
    if ({per_rd_ack6, per_rd_data6, rd_addr_err6} !== 3'b101)
      $display("FAIL err6_per_addr6: ack/data/err=%b, required 101", {per_rd_ack6, per_rd_data6, rd_addr_err6});
    else passed++;
    cpu_read(3'd5);
    checks++;
    if ({cpu_rd_ack6, cpu_rd_data6, rd_addr_err6} !== {1'b1, exp_img[5], 1'b0})
      $display("FAIL err6_addr5: ack/data/err=%b, required %b", {cpu_rd_ack6, cpu_rd_data6, rd_addr_err6}, {1'b1, exp_img[5], 1'b0});
    else passed++;
    tick();
    checks++;
    if ({rd_addr_err6, cpu_rd_ack6} !== 2'b00)
      $display("FAIL err6_pulse: err/ack=%b, required 00", {rd_addr_err6, cpu_rd_ack6});
    else passed++;
  endtask

  task automatic test_reset_mid_scan();
    logic saw_done;
    int   n;
    pins     = 8'hA5;
    scan_req = 1'b1;
    tick();
    scan_req = 1'b0;
    checks++;
    if (scan_busy !== 1'b1) $display("FAIL midscan_busy: scan_busy=%b, required 1", scan_busy);
    else passed++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      saw_done = saw_done | scan_done;
      tick();
    end
    checks++;
    if ({saw_done, scan_busy} !== 2'b00)
      $display("FAIL midscan_abort: saw_done/busy=%b, required 00", {saw_done, scan_busy});
    else passed++;
    exp_img = 8'h00;
    cpu_read(3'd0);
    checks++;
    if ({cpu_rd_ack, cpu_rd_data} !== {1'b1, exp_img[0]})
      $display("FAIL midscan_image: ack/data=%b, required %b", {cpu_rd_ack, cpu_rd_data}, {1'b1, exp_img[0]});
    else passed++;
    scan_req = 1'b1;
    tick();
    scan_req = 1'b0;
    n = 1;
    while (scan_done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n !== SETTLE + 2) $display("FAIL rescan_latency: scan_done after %0d cycles, required %0d", n, SETTLE + 2);
    else passed++;
    exp_img = 8'hA5;
    tick();
    cpu_read(3'd0);
    checks++;
    if ({cpu_rd_ack, cpu_rd_data} !== {1'b1, exp_img[0]})
      $display("FAIL rescan_read: ack/data=%b, required %b", {cpu_rd_ack, cpu_rd_data}, {1'b1, exp_img[0]});
    else passed++;
  endtask

  // Random requesters and scans against a cycle-indexed reference model.
  task automatic test_random();
    logic [7:0] img;
    int   scan_s;
    logic cpu_turn, cpu_pend, per_pend, busy, done, capture, gc, gp, r;
    logic e_cack, e_pack, e_cdat, e_pdat, e_cdat6, e_pdat6, e_err6;
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    img = 8'h00; scan_s = -100; cpu_turn = 1'b1; cpu_pend = 1'b0; per_pend = 1'b0;
    e_cack = 0; e_pack = 0; e_cdat = 0; e_pdat = 0; e_cdat6 = 0; e_pdat6 = 0; e_err6 = 0;
    for (int c = 0; c < 300; c++) begin
      busy    = (c >= scan_s + 1) && (c <= scan_s + SETTLE + 2);
      done    = (c == scan_s + SETTLE + 2);
      capture = (c == scan_s + SETTLE + 1);
      checks++;
      if ({scan_busy, scan_done} !== {busy, done})
        $display("FAIL rand_scan c%0d: busy/done=%b, required %b", c, {scan_busy, scan_done}, {busy, done});
      else passed++;
      checks++;
      if ({cpu_rd_ack, cpu_rd_data, per_rd_ack, per_rd_data, rd_addr_err} !== {e_cack, e_cdat, e_pack, e_pdat, 1'b0})
        $display("FAIL rand_rd8 c%0d: got %b, required %b", c,
                 {cpu_rd_ack, cpu_rd_data, per_rd_ack, per_rd_data, rd_addr_err}, {e_cack, e_cdat, e_pack, e_pdat, 1'b0});
      else passed++;
      checks++;
      if ({cpu_rd_ack6, cpu_rd_data6, per_rd_ack6, per_rd_data6, rd_addr_err6} !== {e_cack, e_cdat6, e_pack, e_pdat6, e_err6})
        $display("FAIL rand_rd6 c%0d: got %b, required %b", c,
                 {cpu_rd_ack6, cpu_rd_data6, per_rd_ack6, per_rd_data6, rd_addr_err6}, {e_cack, e_cdat6, e_pack, e_pdat6, e_err6});
      else passed++;
      if (done) img = pins;                    // new image readable from DONE
      if (e_cack) cpu_pend = 1'b0;
      if (e_pack) per_pend = 1'b0;
      if (!cpu_pend && $urandom_range(0, 2) == 0) begin
        cpu_pend    = 1'b1;
        cpu_rd_addr = 3'($urandom_range(0, 7));
      end
      if (!per_pend && $urandom_range(0, 2) == 0) begin
        per_pend    = 1'b1;
        per_rd_addr = 3'($urandom_range(0, 7));
      end
      cpu_rd_req = cpu_pend;
      per_rd_req = per_pend;
      if (!busy && $urandom_range(0, 3) == 0) pins = 8'($urandom);
      r = ($urandom_range(0, 9) == 0);
      scan_req = r;
      if (r && !busy) scan_s = c;
      gc = 1'b0;
      gp = 1'b0;
      if (!capture) begin
        if (cpu_pend && per_pend) begin
          gc = cpu_turn;
          gp = !cpu_turn;
        end else begin
          gc = cpu_pend;
          gp = per_pend;
        end
      end
      if (gc) cpu_turn = 1'b0;
      if (gp) cpu_turn = 1'b1;
      e_cack = gc;
      e_pack = gp;
      if (gc) begin
        e_cdat  = img[cpu_rd_addr];
        e_cdat6 = (cpu_rd_addr < 3'd6) ? img[cpu_rd_addr] : 1'b0;
      end
      if (gp) begin
        e_pdat  = img[per_rd_addr];
        e_pdat6 = (per_rd_addr < 3'd6) ? img[per_rd_addr] : 1'b0;
      end
      e_err6 = (gc && cpu_rd_addr >= 3'd6) || (gp && per_rd_addr >= 3'd6);
      tick();
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_freeze();
    test_contention();
    test_capture_stall();
    test_addr_err();
    test_reset_mid_scan();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
